// File: rtl/key_pkg.sv
// Shared constants and types for the push-button conditioning path.
package key_pkg;

  localparam int unsigned KEY_DEBOUNCE_DEFAULT = 1_000_000;
  localparam int unsigned KEY_DEBOUNCE_SIM     = 4;
  localparam int unsigned KEY_N_DEFAULT        = 4;

  typedef logic [KEY_N_DEFAULT-1:0] key_vec_t;

  // Counter width for a stability window; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned cycles);
    int unsigned w;
    w = $clog2(cycles);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/key_debounce_if.sv
// Key bundle between the raw button pins and the debounced consumers.
interface key_debounce_if
  import key_pkg::*;
#(
  parameter int unsigned N_KEYS = KEY_N_DEFAULT
);

  logic [N_KEYS-1:0] key_n;
  logic [N_KEYS-1:0] pressed;
  logic [N_KEYS-1:0] press_pulse;
  logic [N_KEYS-1:0] release_pulse;
  logic [N_KEYS-1:0] toggle;

  modport master (
    output key_n,
    input  pressed,
    input  press_pulse,
    input  release_pulse,
    input  toggle
  );

  modport slave (
    input  key_n,
    output pressed,
    output press_pulse,
    output release_pulse,
    output toggle
  );

endinterface

// File: rtl/key_debounce_bit.sv
// One key channel: 2-flop synchroniser, stability counter, level, pulses.
// Optional toggle flop under KEY_DEBOUNCE_TOGGLE_EN.
module debounce_bit
  import key_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = KEY_DEBOUNCE_DEFAULT
) (
  input  logic clk_50MHz,
  input  logic reset,
  input  logic key_n,
  output logic pressed,
  output logic press_pulse,
  output logic release_pulse,
  output logic toggle
);

  localparam int unsigned     CntW   = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES - 1);

  logic            sync1_q, sync2_q;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            stable_q, stable_d;
  logic            press_q, press_d;
  logic            release_q, release_d;

  // Any sample matching the accepted level restarts the window.
  always_comb begin
    cnt_d     = '0;
    stable_d  = stable_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    if (sync2_q != stable_q) begin
      if (cnt_q == CntMax) begin
        stable_d  = sync2_q;
        press_d   = sync2_q;
        release_d = ~sync2_q;
      end else begin
        cnt_d = cnt_q + CntW'(1);
      end
    end
  end

  always_ff @(posedge clk_50MHz or posedge reset) begin
    if (reset) begin
      sync1_q   <= 1'b0;
      sync2_q   <= 1'b0;
      cnt_q     <= '0;
      stable_q  <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      sync1_q   <= ~key_n;
      sync2_q   <= sync1_q;
      cnt_q     <= cnt_d;
      stable_q  <= stable_d;
      press_q   <= press_d;
      release_q <= release_d;
    end
  end

  assign pressed       = stable_q;
  assign press_pulse   = press_q;
  assign release_pulse = release_q;

`ifdef KEY_DEBOUNCE_TOGGLE_EN
  logic toggle_q;

  always_ff @(posedge clk_50MHz or posedge reset) begin
    if (reset) begin
      toggle_q <= 1'b0;
    end else if (press_d) begin
      toggle_q <= ~toggle_q;
    end
  end

  assign toggle = toggle_q;
`else
  assign toggle = 1'b0;
`endif

endmodule

// File: rtl/key_debounce.sv
// Debounces N_KEYS active-low buttons; fans vectors out to debounce_bit.
// Optional per-key toggle level enabled by KEY_DEBOUNCE_TOGGLE_EN.
module key_debounce
  import key_pkg::*;
#(
  parameter int unsigned N_KEYS          = KEY_N_DEFAULT,
  parameter int unsigned DEBOUNCE_CYCLES = KEY_DEBOUNCE_DEFAULT
) (
  input  logic           clk_50MHz,
  input  logic           reset,
  key_debounce_if.slave  keys
);

  logic [N_KEYS-1:0] key_n;
  logic [N_KEYS-1:0] pressed;
  logic [N_KEYS-1:0] press_pulse;
  logic [N_KEYS-1:0] release_pulse;
  logic [N_KEYS-1:0] toggle;

  assign key_n = keys.key_n;

  for (genvar i = 0; i < N_KEYS; i++) begin : g_key
    debounce_bit #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_bit (
      .clk_50MHz     (clk_50MHz),
      .reset         (reset),
      .key_n         (key_n[i]),
      .pressed       (pressed[i]),
      .press_pulse   (press_pulse[i]),
      .release_pulse (release_pulse[i]),
      .toggle        (toggle[i])
    );
  end

  assign keys.pressed       = pressed;
  assign keys.press_pulse   = press_pulse;
  assign keys.release_pulse = release_pulse;
  assign keys.toggle        = toggle;

endmodule

// File: tb/tb_key_debounce.sv
// Directed bench for key_debounce with DEBOUNCE_CYCLES = 4, N_KEYS = 4.
module tb_key_debounce;
  import key_pkg::*;

`ifdef KEY_DEBOUNCE_TOGGLE_EN
  localparam bit TogEn = 1'b1;
`else
  localparam bit TogEn = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_checks = 0;
  int   n_pass = 0;

  always #5 clk = ~clk;

  key_debounce_if #(.N_KEYS(KEY_N_DEFAULT)) keys ();

  key_debounce #(
    .N_KEYS          (KEY_N_DEFAULT),
    .DEBOUNCE_CYCLES (KEY_DEBOUNCE_SIM)
  ) dut (
    .clk_50MHz (clk),
    .reset     (reset),
    .keys      (keys)
  );

  // Advance to just after the next rising edge; inputs change and outputs are sampled here.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    key_vec_t exp_tog;
    exp_tog = TogEn ? 4'b1111 : 4'b0000;
    keys.key_n = 4'b0000;
    reset = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      n_checks++;
      if ({keys.pressed, keys.press_pulse, keys.release_pulse, keys.toggle} !== 16'h0)
        $display("FAIL reset_hold: outputs=%h required 0000", {keys.pressed, keys.press_pulse,
                 keys.release_pulse, keys.toggle});
      else n_pass++;
    end
    reset = 1'b0;
    for (int k = 0; k < 5; k++) begin
      step();
      n_checks++;
      if (keys.pressed !== 4'b0000 || keys.press_pulse !== 4'b0000)
        $display("FAIL reset_early: edge %0d pressed=%b pulse=%b required 0000", k,
                 keys.pressed, keys.press_pulse);
      else n_pass++;
    end
    step();
    n_checks++;
    if (keys.pressed !== 4'b1111 || keys.press_pulse !== 4'b1111 || keys.toggle !== exp_tog)
      $display("FAIL reset_press: pressed=%b pulse=%b toggle=%b required 1111 1111 %b",
               keys.pressed, keys.press_pulse, keys.toggle, exp_tog);
    else n_pass++;
    step();
    n_checks++;
    if (keys.pressed !== 4'b1111 || keys.press_pulse !== 4'b0000)
      $display("FAIL reset_pulse_width: pressed=%b pulse=%b required 1111 0000",
               keys.pressed, keys.press_pulse);
    else n_pass++;
    keys.key_n = 4'b1111;
    for (int k = 0; k < 6; k++) step();
    n_checks++;
    if (keys.pressed !== 4'b0000 || keys.release_pulse !== 4'b1111 || keys.toggle !== exp_tog)
      $display("FAIL reset_release: pressed=%b rel=%b toggle=%b required 0000 1111 %b",
               keys.pressed, keys.release_pulse, keys.toggle, exp_tog);
    else n_pass++;
    step();
  endtask

  task automatic test_press_release();
    keys.key_n = 4'b1101;
    for (int k = 0; k < 5; k++) begin
      step();
      n_checks++;
      if (keys.press_pulse !== 4'b0000 || keys.pressed !== 4'b0000)
        $display("FAIL press_early: edge %0d pressed=%b pulse=%b required 0000", k,
                 keys.pressed, keys.press_pulse);
      else n_pass++;
    end
    step();
    n_checks++;
    if (keys.press_pulse !== 4'b0010 || keys.pressed !== 4'b0010 || keys.release_pulse !== 4'b0)
      $display("FAIL press_edge: pressed=%b pulse=%b rel=%b required 0010 0010 0000",
               keys.pressed, keys.press_pulse, keys.release_pulse);
    else n_pass++;
    for (int k = 0; k < 4; k++) begin
      step();
      n_checks++;
      if (keys.press_pulse !== 4'b0000 || keys.pressed !== 4'b0010)
        $display("FAIL press_hold: cycle %0d pressed=%b pulse=%b required 0010 0000", k,
                 keys.pressed, keys.press_pulse);
      else n_pass++;
    end
    keys.key_n = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      step();
      n_checks++;
      if (keys.release_pulse !== 4'b0000 || keys.pressed !== 4'b0010)
        $display("FAIL release_early: edge %0d pressed=%b rel=%b required 0010 0000", k,
                 keys.pressed, keys.release_pulse);
      else n_pass++;
    end
    step();
    n_checks++;
    if (keys.release_pulse !== 4'b0010 || keys.pressed !== 4'b0000 || keys.press_pulse !== 4'b0)
      $display("FAIL release_edge: pressed=%b rel=%b pulse=%b required 0000 0010 0000",
               keys.pressed, keys.release_pulse, keys.press_pulse);
    else n_pass++;
    step();
    n_checks++;
    if (keys.release_pulse !== 4'b0000)
      $display("FAIL release_width: rel=%b required 0000", keys.release_pulse);
    else n_pass++;
  endtask

  task automatic test_bounce();
    key_vec_t pattern [4];
    pattern = '{4'b1011, 4'b1011, 4'b1011, 4'b1111};
    for (int k = 0; k < 4; k++) begin
      keys.key_n = pattern[k];
      step();
      n_checks++;
      if (keys.press_pulse !== 4'b0000 || keys.pressed !== 4'b0000)
        $display("FAIL bounce_glitch: cycle %0d pressed=%b pulse=%b required 0000", k,
                 keys.pressed, keys.press_pulse);
      else n_pass++;
    end
    keys.key_n = 4'b1011;
    for (int k = 0; k < 5; k++) begin
      step();
      n_checks++;
      if (keys.press_pulse !== 4'b0000 || keys.pressed !== 4'b0000)
        $display("FAIL bounce_early: edge %0d pressed=%b pulse=%b required 0000", k,
                 keys.pressed, keys.press_pulse);
      else n_pass++;
    end
    step();
    n_checks++;
    if (keys.press_pulse !== 4'b0100 || keys.pressed !== 4'b0100)
      $display("FAIL bounce_press: pressed=%b pulse=%b required 0100 0100",
               keys.pressed, keys.press_pulse);
    else n_pass++;
    step();
    n_checks++;
    if (keys.press_pulse !== 4'b0000 || keys.pressed !== 4'b0100)
      $display("FAIL bounce_single: pressed=%b pulse=%b required 0100 0000",
               keys.pressed, keys.press_pulse);
    else n_pass++;
    keys.key_n = 4'b1111;
    for (int k = 0; k < 7; k++) step();
    n_checks++;
    if (keys.pressed !== 4'b0000)
      $display("FAIL bounce_release: pressed=%b required 0000", keys.pressed);
    else n_pass++;
  endtask

  task automatic test_simultaneous();
    keys.key_n = 4'b0110;
    for (int k = 0; k < 5; k++) step();
    n_checks++;
    if (keys.press_pulse !== 4'b0000)
      $display("FAIL simul_early: pulse=%b required 0000", keys.press_pulse);
    else n_pass++;
    step();
    n_checks++;
    if (keys.press_pulse !== 4'b1001 || keys.pressed !== 4'b1001)
      $display("FAIL simul_press: pressed=%b pulse=%b required 1001 1001",
               keys.pressed, keys.press_pulse);
    else n_pass++;
    keys.key_n = 4'b1111;
    for (int k = 0; k < 6; k++) step();
    n_checks++;
    if (keys.release_pulse !== 4'b1001 || keys.pressed !== 4'b0000)
      $display("FAIL simul_release: pressed=%b rel=%b required 0000 1001",
               keys.pressed, keys.release_pulse);
    else n_pass++;
    step();
  endtask

  // Every key has been pressed an even number of times by now, so toggle starts at 0000.
  task automatic test_toggle();
    key_vec_t exp_seq [3];
    exp_seq = TogEn ? '{4'b0001, 4'b0000, 4'b0001} : '{4'b0000, 4'b0000, 4'b0000};
    for (int p = 0; p < 3; p++) begin
      keys.key_n = 4'b1110;
      for (int k = 0; k < 6; k++) step();
      n_checks++;
      if (keys.press_pulse !== 4'b0001 || keys.toggle !== exp_seq[p])
        $display("FAIL toggle_press%0d: pulse=%b toggle=%b required 0001 %b", p,
                 keys.press_pulse, keys.toggle, exp_seq[p]);
      else n_pass++;
      keys.key_n = 4'b1111;
      for (int k = 0; k < 6; k++) step();
      n_checks++;
      if (keys.release_pulse !== 4'b0001 || keys.toggle !== exp_seq[p])
        $display("FAIL toggle_release%0d: rel=%b toggle=%b required 0001 %b", p,
                 keys.release_pulse, keys.toggle, exp_seq[p]);
      else n_pass++;
      step();
    end
  endtask

  task automatic test_mid_count_reset();
    keys.key_n = 4'b1101;
    // sync1, sync2, then two counting edges: count is 2 here.
    for (int k = 0; k < 4; k++) step();
    n_checks++;
    if (keys.press_pulse !== 4'b0000 || keys.pressed !== 4'b0000)
      $display("FAIL midrst_before: pressed=%b pulse=%b required 0000",
               keys.pressed, keys.press_pulse);
    else n_pass++;
    reset = 1'b1;
    #1;
    n_checks++;
    if ({keys.pressed, keys.press_pulse, keys.release_pulse, keys.toggle} !== 16'h0)
      $display("FAIL midrst_async: outputs=%h required 0000", {keys.pressed, keys.press_pulse,
               keys.release_pulse, keys.toggle});
    else n_pass++;
    step();
    step();
    reset = 1'b0;
    for (int k = 0; k < 5; k++) begin
      step();
      n_checks++;
      if (keys.press_pulse !== 4'b0000 || keys.pressed !== 4'b0000)
        $display("FAIL midrst_early: edge %0d pressed=%b pulse=%b required 0000", k,
                 keys.pressed, keys.press_pulse);
      else n_pass++;
    end
    step();
    n_checks++;
    if (keys.press_pulse !== 4'b0010 || keys.pressed !== 4'b0010 ||
        keys.toggle !== (TogEn ? 4'b0010 : 4'b0000))
      $display("FAIL midrst_press: pressed=%b pulse=%b toggle=%b required 0010 0010 %b",
               keys.pressed, keys.press_pulse, keys.toggle, TogEn ? 4'b0010 : 4'b0000);
    else n_pass++;
    keys.key_n = 4'b1111;
    for (int k = 0; k < 7; k++) step();
  endtask

  initial begin
    keys.key_n = 4'b1111;
    test_reset();
    test_press_release();
    test_bounce();
    test_simultaneous();
    test_toggle();
    test_mid_count_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
